// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/WRITEBACK control FSM
// producing datapath strobes from a latched instruction register.
module instr_sequencer #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_cpu,
    input  logic                   cpu_enable,
    input  logic                   wwd_enable,
    input  logic [15:0]            inst,
    output logic                   pc_write_en,
    output logic                   pc_src,
    output logic                   reg_write_en,
    output logic                   reg_dst,
    output logic                   alu_src_imm,
    output logic [1:0]             alu_op,
    output logic                   output_port_load,
    output logic [COUNT_WIDTH-1:0] inst_count,
    output logic [1:0]             state,
    output logic                   illegal
);

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_ADI     = 3'd1,
        CLS_LHI     = 3'd2,
        CLS_JMP     = 3'd3,
        CLS_ADD     = 3'd4,
        CLS_WWD     = 3'd5
    } class_t;

    localparam logic [3:0] OP_ADI  = 4'd4;
    localparam logic [3:0] OP_LHI  = 4'd6;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_RTYP = 4'd15;
    localparam logic [5:0] FN_ADD  = 6'd0;
    localparam logic [5:0] FN_WWD  = 6'd28;

    state_t      cur_state;
    state_t      next_state;
    logic [15:0] ir;
    class_t      cls;

    logic pc_write_raw;
    logic reg_write_raw;
    logic port_load_raw;
    logic alu_phase;

    always_comb begin
        cls = CLS_ILLEGAL;
        case (ir[15:12])
            OP_ADI:  cls = CLS_ADI;
            OP_LHI:  cls = CLS_LHI;
            OP_JMP:  cls = CLS_JMP;
            OP_RTYP: begin
                if (ir[5:0] == FN_ADD)
                    cls = CLS_ADD;
                else if (ir[5:0] == FN_WWD)
                    cls = CLS_WWD;
            end
            default: cls = CLS_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk or posedge reset_cpu) begin
        if (reset_cpu)
            cur_state <= FETCH;
        else if (cpu_enable)
            cur_state <= next_state;
    end

    always_ff @(posedge clk or posedge reset_cpu) begin
        if (reset_cpu)
            ir <= 16'h0000;
        else if (cpu_enable && cur_state == FETCH)
            ir <= inst;
    end

    // pc_write_en is already gated by cpu_enable, so the count freezes with the FSM.
    always_ff @(posedge clk or posedge reset_cpu) begin
        if (reset_cpu)
            inst_count <= '0;
        else if (pc_write_en)
            inst_count <= inst_count + COUNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge reset_cpu) begin
        if (reset_cpu)
            illegal <= 1'b0;
        else if (cpu_enable && cur_state == DECODE && cls == CLS_ILLEGAL)
            illegal <= 1'b1;
    end

    always_comb begin
        next_state    = cur_state;
        pc_write_raw  = 1'b0;
        pc_src        = 1'b0;
        reg_write_raw = 1'b0;
        port_load_raw = 1'b0;
        alu_phase     = 1'b0;
        case (cur_state)
            FETCH: begin
                next_state = DECODE;
            end
            DECODE: begin
                if (cls == CLS_JMP) begin
                    next_state   = FETCH;
                    pc_write_raw = 1'b1;
                    pc_src       = 1'b1;
                end else if (cls == CLS_ILLEGAL) begin
                    next_state   = FETCH;
                    pc_write_raw = 1'b1;
                end else begin
                    next_state = EXECUTE;
                end
            end
            EXECUTE: begin
                next_state = WRITEBACK;
                alu_phase  = 1'b1;
            end
            WRITEBACK: begin
                next_state    = FETCH;
                alu_phase     = 1'b1;
                pc_write_raw  = 1'b1;
                reg_write_raw = (cls == CLS_ADI) || (cls == CLS_LHI) || (cls == CLS_ADD);
                port_load_raw = (cls == CLS_WWD) && wwd_enable;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    // ALU controls are held steady across EXECUTE and WRITEBACK so the result is stable at the write.
    always_comb begin
        reg_dst     = 1'b0;
        alu_src_imm = 1'b0;
        alu_op      = 2'b00;
        if (alu_phase) begin
            case (cls)
                CLS_ADI: begin
                    alu_src_imm = 1'b1;
                end
                CLS_LHI: begin
                    alu_src_imm = 1'b1;
                    alu_op      = 2'b01;
                end
                CLS_ADD: begin
                    reg_dst = 1'b1;
                end
                default: begin
                    reg_dst     = 1'b0;
                    alu_src_imm = 1'b0;
                    alu_op      = 2'b00;
                end
            endcase
        end
    end

    assign pc_write_en      = pc_write_raw && cpu_enable;
    assign reg_write_en     = reg_write_raw && cpu_enable;
    assign output_port_load = port_load_raw && cpu_enable;
    assign state            = cur_state;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes hand-computed per-cycle
// expectations, a monitor pops them at mid-cycle (or on demand) and compares.
module tb_instr_sequencer;

    localparam int CW = 4;

    logic          clk;
    logic          reset_cpu;
    logic          cpu_enable;
    logic          wwd_enable;
    logic [15:0]   inst;
    logic          pc_write_en;
    logic          pc_src;
    logic          reg_write_en;
    logic          reg_dst;
    logic          alu_src_imm;
    logic [1:0]    alu_op;
    logic          output_port_load;
    logic [CW-1:0] inst_count;
    logic [1:0]    state;
    logic          illegal;

    typedef struct {
        string         name;
        logic [1:0]    st;
        logic          pcw;
        logic          pcs;
        logic          rwe;
        logic          rdst;
        logic          imm;
        logic [1:0]    op;
        logic          opl;
        logic [CW-1:0] cnt;
        logic          ill;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    event sample_req;

    instr_sequencer #(.COUNT_WIDTH(CW)) dut (
        .clk              (clk),
        .reset_cpu        (reset_cpu),
        .cpu_enable       (cpu_enable),
        .wwd_enable       (wwd_enable),
        .inst             (inst),
        .pc_write_en      (pc_write_en),
        .pc_src           (pc_src),
        .reg_write_en     (reg_write_en),
        .reg_dst          (reg_dst),
        .alu_src_imm      (alu_src_imm),
        .alu_op           (alu_op),
        .output_port_load (output_port_load),
        .inst_count       (inst_count),
        .state            (state),
        .illegal          (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input string name, input logic [1:0] st, input logic pcw,
                                input logic pcs, input logic rwe, input logic rdst,
                                input logic imm, input logic [1:0] op, input logic opl,
                                input int cnt, input logic ill);
        exp_t e;
        e.name = name; e.st = st; e.pcw = pcw; e.pcs = pcs; e.rwe = rwe;
        e.rdst = rdst; e.imm = imm; e.op = op; e.opl = opl;
        e.cnt = cnt[CW-1:0]; e.ill = ill;
        return e;
    endfunction

    task automatic checkOutput(input exp_t e);
        logic [15:0] act;
        logic [15:0] req;
        act = {state, pc_write_en, pc_src, reg_write_en, reg_dst, alu_src_imm,
               alu_op, output_port_load, inst_count, illegal};
        req = {e.st, e.pcw, e.pcs, e.rwe, e.rdst, e.imm, e.op, e.opl, e.cnt, e.ill};
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("[TB] FAIL %s: got st=%0d pcw=%b pcs=%b rwe=%b rdst=%b imm=%b op=%b opl=%b cnt=%0d ill=%b, expected st=%0d pcw=%b pcs=%b rwe=%b rdst=%b imm=%b op=%b opl=%b cnt=%0d ill=%b",
                     e.name, state, pc_write_en, pc_src, reg_write_en, reg_dst, alu_src_imm,
                     alu_op, output_port_load, inst_count, illegal,
                     e.st, e.pcw, e.pcs, e.rwe, e.rdst, e.imm, e.op, e.opl, e.cnt, e.ill);
        end
    endtask

    // Monitor: one expectation per mid-cycle sample, or per explicit between-edge request.
    always begin
        @(negedge clk or sample_req);
        if (sb.size() > 0)
            checkOutput(sb.pop_front());
    end

    // Drive inputs just after an edge; the expectation describes the cycle that edge started.
    task automatic applyStimulus(input logic [15:0] i, input logic en, input logic w, input exp_t e);
        @(posedge clk);
        #1;
        inst       = i;
        cpu_enable = en;
        wwd_enable = w;
        sb.push_back(e);
    endtask

    task automatic sampleNow(input exp_t e);
        sb.push_back(e);
        #1;
        -> sample_req;
    endtask

    initial begin
        #20000;
        n_fails++;
        $display("[TB] FAIL timeout: simulation did not complete, pending=%0d expected 0", sb.size());
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        reset_cpu  = 1'b1;
        inst       = 16'h6101;
        cpu_enable = 1'b1;
        wwd_enable = 1'b1;
        #2;
        sampleNow(mk("reset", 0, 0,0,0,0,0,2'b00,0, 0, 0));
        #9;
        reset_cpu = 1'b0;
        sampleNow(mk("fetch_after_reset", 0, 0,0,0,0,0,2'b00,0, 0, 0));

        // LHI
        applyStimulus(16'h6101, 1, 1, mk("lhi_decode",    1, 0,0,0,0,0,2'b00,0, 0, 0));
        applyStimulus(16'h6101, 1, 1, mk("lhi_execute",   2, 0,0,0,0,1,2'b01,0, 0, 0));
        applyStimulus(16'h6101, 1, 1, mk("lhi_writeback", 3, 1,0,1,0,1,2'b01,0, 0, 0));
        applyStimulus(16'h9015, 1, 1, mk("lhi_retired",   0, 0,0,0,0,0,2'b00,0, 1, 0));
        // JMP
        applyStimulus(16'h9015, 1, 1, mk("jmp_decode",    1, 1,1,0,0,0,2'b00,0, 1, 0));
        applyStimulus(16'hf81c, 1, 1, mk("jmp_retired",   0, 0,0,0,0,0,2'b00,0, 2, 0));
        // WWD with and without wwd_enable
        applyStimulus(16'hf81c, 1, 1, mk("wwd_decode",    1, 0,0,0,0,0,2'b00,0, 2, 0));
        applyStimulus(16'hf81c, 1, 1, mk("wwd_execute",   2, 0,0,0,0,0,2'b00,0, 2, 0));
        applyStimulus(16'hf81c, 1, 1, mk("wwd_wb_en",     3, 1,0,0,0,0,2'b00,1, 2, 0));
        applyStimulus(16'hf81c, 1, 0, mk("wwd_retired",   0, 0,0,0,0,0,2'b00,0, 3, 0));
        applyStimulus(16'hf81c, 1, 0, mk("wwd2_decode",   1, 0,0,0,0,0,2'b00,0, 3, 0));
        applyStimulus(16'hf81c, 1, 0, mk("wwd2_execute",  2, 0,0,0,0,0,2'b00,0, 3, 0));
        applyStimulus(16'hf81c, 1, 0, mk("wwd2_wb_dis",   3, 1,0,0,0,0,2'b00,0, 3, 0));
        applyStimulus(16'hf6c0, 1, 0, mk("wwd2_retired",  0, 0,0,0,0,0,2'b00,0, 4, 0));
        // ADD with a freeze in EXECUTE and a one-cycle freeze in WRITEBACK
        applyStimulus(16'hf6c0, 1, 0, mk("add_decode",    1, 0,0,0,0,0,2'b00,0, 4, 0));
        applyStimulus(16'hf6c0, 0, 0, mk("add_exec_frz0", 2, 0,0,0,1,0,2'b00,0, 4, 0));
        applyStimulus(16'hf6c0, 0, 0, mk("add_exec_frz1", 2, 0,0,0,1,0,2'b00,0, 4, 0));
        applyStimulus(16'hf6c0, 0, 0, mk("add_exec_frz2", 2, 0,0,0,1,0,2'b00,0, 4, 0));
        applyStimulus(16'hf6c0, 1, 0, mk("add_exec_resume", 2, 0,0,0,1,0,2'b00,0, 4, 0));
        applyStimulus(16'hf6c0, 0, 0, mk("add_wb_frozen", 3, 0,0,0,1,0,2'b00,0, 4, 0));
        applyStimulus(16'hf6c0, 1, 0, mk("add_wb",        3, 1,0,1,1,0,2'b00,0, 4, 0));
        applyStimulus(16'hf6c0, 1, 0, mk("add_retired",   0, 0,0,0,0,0,2'b00,0, 5, 0));
        // Second ADD, aborted by a reset pulse in WRITEBACK
        applyStimulus(16'hf6c0, 1, 0, mk("add2_decode",   1, 0,0,0,0,0,2'b00,0, 5, 0));
        applyStimulus(16'hf6c0, 1, 0, mk("add2_execute",  2, 0,0,0,1,0,2'b00,0, 5, 0));
        applyStimulus(16'hf6c0, 1, 0, mk("add2_wb",       3, 1,0,1,1,0,2'b00,0, 5, 0));
        @(negedge clk);
        #1;
        reset_cpu = 1'b1;
        inst      = 16'h2000;
        sampleNow(mk("reset_mid_wb", 0, 0,0,0,0,0,2'b00,0, 0, 0));
        reset_cpu = 1'b0;
        sampleNow(mk("fetch_after_pulse", 0, 0,0,0,0,0,2'b00,0, 0, 0));
        // Two illegal encodings, then a legal one to show the flag is sticky
        applyStimulus(16'h2000, 1, 0, mk("ill1_decode",   1, 1,0,0,0,0,2'b00,0, 0, 0));
        applyStimulus(16'hf0ff, 1, 0, mk("ill1_retired",  0, 0,0,0,0,0,2'b00,0, 1, 1));
        applyStimulus(16'hf0ff, 1, 0, mk("ill2_decode",   1, 1,0,0,0,0,2'b00,0, 1, 1));
        applyStimulus(16'h6101, 1, 0, mk("ill2_retired",  0, 0,0,0,0,0,2'b00,0, 2, 1));
        applyStimulus(16'h6101, 1, 0, mk("lhi3_decode",   1, 0,0,0,0,0,2'b00,0, 2, 1));
        applyStimulus(16'h6101, 1, 0, mk("lhi3_execute",  2, 0,0,0,0,1,2'b01,0, 2, 1));
        applyStimulus(16'h6101, 1, 0, mk("lhi3_wb",       3, 1,0,1,0,1,2'b01,0, 2, 1));
        applyStimulus(16'h9015, 1, 0, mk("lhi3_retired",  0, 0,0,0,0,0,2'b00,0, 3, 1));
        // Chain of jumps drives the narrow counter through its wrap
        for (int k = 0; k < 14; k++) begin
            applyStimulus(16'h9015, 1, 0, mk("wrap_jmp_decode",  1, 1,1,0,0,0,2'b00,0, 3 + k, 1));
            applyStimulus(16'h9015, 1, 0, mk("wrap_jmp_retired", 0, 0,0,0,0,0,2'b00,0, 4 + k, 1));
        end

        repeat (2) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_fails++;
            $display("[TB] FAIL scoreboard_drain: pending=%0d expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
